// File: rtl/sprite_collision_scanner.sv
// Sequential sprite collision scanner: fetches one reference sprite, then
// walks the whole sprite bank. Each active slot other than the reference is
// paired with the reference for the external combinational checker, and the
// hits are collected into a per-slot mask plus summary flags.
module sprite_collision_scanner #(
  parameter int N_SLOTS = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   ref_slot,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [31:0]         rd_data,
  output logic [31:0]         pair_a,
  output logic [31:0]         pair_b,
  input  logic                pair_hit,
  output logic                busy,
  output logic                done,
  output logic                collided,
  output logic [ADDR_W-1:0]   first_hit,
  output logic [N_SLOTS-1:0]  hit_mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REF,
    S_LATCH_REF,
    S_SCAN,
    S_DONE
  } state_t;

  // The compare index is one bit wider than a slot address so that a bank of
  // exactly 2^ADDR_W slots still reaches its last index without wrapping.
  localparam logic [ADDR_W:0]   LAST_K    = (ADDR_W+1)'(N_SLOTS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SLOTS - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    ref_slot_q, ref_slot_d;
  logic [31:0]          ref_q, ref_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]      k_q, k_d;
  logic [N_SLOTS-1:0]   mask_q, mask_d;
  logic                 collided_q, collided_d;
  logic [ADDR_W-1:0]    first_q, first_d;
  logic                 qualify;

  // State and result registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ref_slot_q <= '0;
      ref_q      <= '0;
      rd_addr_q  <= '0;
      k_q        <= '0;
      mask_q     <= '0;
      collided_q <= 1'b0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      ref_slot_q <= ref_slot_d;
      ref_q      <= ref_d;
      rd_addr_q  <= rd_addr_d;
      k_q        <= k_d;
      mask_q     <= mask_d;
      collided_q <= collided_d;
      first_q    <= first_d;
    end
  end

  // Next-state logic: sequencing of the bank reads and hit accumulation.
  always_comb begin
    state_d    = state_q;
    ref_slot_d = ref_slot_q;
    ref_d      = ref_q;
    rd_addr_d  = rd_addr_q;
    k_d        = k_q;
    mask_d     = mask_q;
    collided_d = collided_q;
    first_d    = first_q;
    // A slot counts only if it is not the reference itself and is active.
    qualify    = (k_q != {1'b0, ref_slot_q}) && rd_data[29];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ref_slot_d = ref_slot;
          mask_d     = '0;
          collided_d = 1'b0;
          first_d    = '0;
          rd_addr_d  = ref_slot;
          state_d    = S_FETCH_REF;
        end
      end
      S_FETCH_REF: begin
        rd_addr_d = '0;
        state_d   = S_LATCH_REF;
      end
      S_LATCH_REF: begin
        ref_d     = rd_data;
        rd_addr_d = ADDR_W'(1);
        k_d       = '0;
        // An inactive reference cannot collide with anything.
        state_d   = rd_data[29] ? S_SCAN : S_DONE;
      end
      S_SCAN: begin
        if (qualify && pair_hit) begin
          mask_d[k_q[ADDR_W-1:0]] = 1'b1;
          // Slots are visited in ascending order, so the first hit is the lowest.
          if (!collided_q) begin
            first_d    = k_q[ADDR_W-1:0];
            collided_d = 1'b1;
          end
        end
        // The read address leads the compare index by one and parks on the
        // last slot so no read beyond the bank is ever issued.
        if (rd_addr_q != LAST_ADDR) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        if (k_q == LAST_K) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + (ADDR_W+1)'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr   = rd_addr_q;
  assign pair_a    = ref_q;
  assign pair_b    = rd_data;
  assign busy      = (state_q == S_FETCH_REF) || (state_q == S_LATCH_REF) ||
                     (state_q == S_SCAN);
  assign done      = (state_q == S_DONE);
  assign collided  = collided_q;
  assign first_hit = first_q;
  assign hit_mask  = mask_q;

endmodule

// File: tb/tb_sprite_collision_scanner.sv
// Bench for sprite_collision_scanner: a sprite bank with registered reads and
// a selectable pair checker surround the DUT; a scan-level model predicts the
// outputs cycle by cycle from the bank contents captured at each start.
module tb_sprite_collision_scanner;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] ref_slot;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [31:0]   pair_a;
  logic [31:0]   pair_b;
  logic          pair_hit;
  logic          busy;
  logic          done;
  logic          collided;
  logic [AW-1:0] first_hit;
  logic [N-1:0]  hit_mask;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [N];
  int          mode = 0;

  sprite_collision_scanner #(.N_SLOTS(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .ref_slot(ref_slot),
    .rd_addr(rd_addr), .rd_data(rd_data), .pair_a(pair_a), .pair_b(pair_b),
    .pair_hit(pair_hit), .busy(busy), .done(done), .collided(collided),
    .first_hit(first_hit), .hit_mask(hit_mask)
  );

  always #5 clk = ~clk;

  // Sprite bank: registered read
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Checker: 0 = 20x20 bounding-box overlap, 1 = always hit, 2 = offset parity
  function automatic logic hit_fn(input logic [31:0] a, input logic [31:0] b, input int md);
    int dx, dy;
    case (md)
      1: return 1'b1;
      2: return ^(a[8:0] ^ b[8:0]);
      default: begin
        dx = int'(a[28:19]) - int'(b[28:19]);
        dy = int'(a[18:9])  - int'(b[18:9]);
        return (dx > -20) && (dx < 20) && (dy > -20) && (dy < 20);
      end
    endcase
  endfunction

  assign pair_hit = hit_fn(pair_a, pair_b, mode);

  function automatic logic [31:0] w(input logic act, input int x, input int y, input int off);
    return {2'b00, act, 10'(x), 10'(y), 9'(off)};
  endfunction

  function automatic logic [N-1:0] lowmask(input int n);
    logic [63:0] t;
    t = (64'd1 << n) - 64'd1;
    return t[N-1:0];
  endfunction

  function automatic logic [AW-1:0] lowest(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return AW'(i);
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
  endtask

  // Scan-level model: cycles elapsed since the accepted start, the final
  // result set computed from the bank contents, and results of the last scan.
  int           m_cnt = 0;
  int           m_lat = 3;
  logic [AW-1:0] m_ref = '0;
  logic [31:0]  m_refw = '0;
  logic [N-1:0] fin_mask = '0;
  logic [N-1:0] res_mask = '0;

  initial begin
    logic [N-1:0]  exp_m;
    logic [AW-1:0] exp_addr;
    int            seen;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cnt    = 0;
        res_mask = '0;
      end else if (m_cnt == 0) begin
        if (start) begin
          m_ref    = ref_slot;
          m_refw   = mem[ref_slot];
          fin_mask = '0;
          if (m_refw[29]) begin
            for (int k = 0; k < N; k++)
              if (k != int'(m_ref) && mem[k][29] && hit_fn(m_refw, mem[k], mode))
                fin_mask[k] = 1'b1;
          end
          m_lat = m_refw[29] ? N + 3 : 3;
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt > m_lat) begin
          m_cnt    = 0;
          res_mask = fin_mask;
        end
      end
      #1;
      if (m_cnt == 0) begin
        exp_m = res_mask;
      end else begin
        seen  = (m_cnt < 3) ? 0 : ((m_cnt - 3 > N) ? N : m_cnt - 3);
        exp_m = fin_mask & lowmask(seen);
      end
      chk("busy", busy, (m_cnt >= 1) && (m_cnt < m_lat));
      chk("done", done, (m_cnt != 0) && (m_cnt == m_lat));
      chk("hit_mask", hit_mask, exp_m);
      chk("collided", collided, |exp_m);
      chk("first_hit", first_hit, lowest(exp_m));
      chk("pair_b", pair_b, rd_data);
      if (m_cnt >= 1) begin
        exp_addr = (m_cnt == 1) ? m_ref : AW'((m_cnt - 2 > N - 1) ? N - 1 : m_cnt - 2);
        chk("rd_addr", rd_addr, exp_addr);
      end
      if (m_cnt >= 3) chk("pair_a", pair_a, m_refw);
    end
  end

  // Pulse start for one cycle, optionally re-pulse it at poke_at, and count
  // cycles until done (bounded).
  task automatic run_scan(input logic [AW-1:0] slot, input int poke_at, output int lat);
    int cnt;
    @(negedge clk);
    start    = 1'b1;
    ref_slot = slot;
    cnt      = 0;
    do begin
      @(negedge clk);
      cnt++;
      start = (cnt == poke_at);
    end while (!done && cnt < 100);
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    lat = cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int r;
    int poke;
    reset    = 1'b1;
    start    = 1'b0;
    ref_slot = '0;
    mode     = 0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", hit_mask, 0);
    chk("rst_collided", collided, 0);
    chk("rst_first", first_hit, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_pair_a", pair_a, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Collision found
    mem[3] = w(1, 100, 100, 0);
    mem[7] = w(1, 110, 105, 0);
    run_scan(3, -1, lat);
    chk("t1_latency", lat, 35);
    chk("t1_mask", hit_mask, 32'h0000_0080);
    chk("t1_first", first_hit, 7);
    chk("t1_collided", collided, 1);

    // No collision, started the cycle after done
    mem[7] = w(1, 300, 105, 0);
    run_scan(3, -1, lat);
    chk("t2_latency", lat, 35);
    chk("t2_mask", hit_mask, 0);
    chk("t2_collided", collided, 0);
    chk("t2_first", first_hit, 0);

    // Start during the done cycle is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_busy", busy, 0);

    // Multiple hits, self-exclusion, start pulsed while busy
    clear_mem();
    mode   = 1;
    mem[5] = w(1, 200, 200, 1);
    mem[2] = w(1, 205, 200, 2);
    mem[9] = w(1, 200, 210, 3);
    mem[31] = w(1, 210, 190, 4);
    run_scan(5, 10, lat);
    chk("t3_latency", lat, 35);
    chk("t3_mask", hit_mask, 32'h8000_0204);
    chk("t3_first", first_hit, 2);
    chk("t3_collided", collided, 1);

    // Inactive reference
    mem[5] = w(0, 200, 200, 1);
    run_scan(5, -1, lat);
    chk("t4_latency", lat, 3);
    chk("t4_mask", hit_mask, 0);
    chk("t4_collided", collided, 0);
    chk("t4_rd_addr", rd_addr, 1);

    // Reset mid-scan
    clear_mem();
    mode   = 0;
    mem[3] = w(1, 100, 100, 0);
    mem[7] = w(1, 110, 105, 0);
    @(negedge clk);
    start    = 1'b1;
    ref_slot = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mask", hit_mask, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_pair_a", pair_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    reset = 1'b0;
    run_scan(3, -1, lat);
    chk("t5_latency", lat, 35);
    chk("t5_mask", hit_mask, 32'h0000_0080);

    // Randomized scans
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < N; k++)
        mem[k] = w($urandom_range(0, 1), 90 + $urandom_range(0, 40),
                   90 + $urandom_range(0, 40), $urandom_range(0, 511));
      mode = $urandom_range(0, 2);
      r    = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) != 0) mem[r][29] = 1'b1;
      poke = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : -1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_scan(AW'(r), poke, lat);
      chk("rand_latency", lat, mem[r][29] ? 35 : 3);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
